// File: rtl/muxl1_serializer.sv
// Lane serializer: captures a group of LANES parallel lanes and emits them
// one per clock, lowest lane first, tagged with the source lane index.
module muxl1_serializer #(
  parameter int WIDTH        = 8,
  parameter int LANES        = 4,
  parameter int SKIP_INVALID = 0,
  localparam int IW          = $clog2(LANES)
) (
  input  logic                   clk_f,
  input  logic                   reset_L,
  input  logic [WIDTH*LANES-1:0] data_in,
  input  logic [LANES-1:0]       valid_in,
  input  logic                   load,
  output logic                   ready,
  output logic [WIDTH-1:0]       data_out,
  output logic                   valid_out,
  output logic [IW-1:0]          lane_out,
  output logic                   overrun
);

  localparam bit SKIP = (SKIP_INVALID != 0);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_reg, state_next;
  logic [IW-1:0]     ptr_reg, ptr_next;
  logic [WIDTH-1:0]  hold_data_reg  [LANES];
  logic              hold_valid_reg [LANES];

  logic [LANES-1:0]  above_mask;
  logic [IW-1:0]     in_first;
  logic [IW-1:0]     skip_next;
  logic              skip_more;
  logic              last_slot;
  logic              accept;
  logic              take;
  logic [IW-1:0]     first_lane;

  // Holding registers, one lane per generate iteration.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign above_mask[gi] = hold_valid_reg[gi] && (gi > int'(ptr_reg));

    always_ff @(posedge clk_f) begin
      if (!reset_L) begin
        hold_data_reg[gi]  <= '0;
        hold_valid_reg[gi] <= 1'b0;
      end else if (take) begin
        hold_data_reg[gi]  <= data_in[gi*WIDTH +: WIDTH];
        hold_valid_reg[gi] <= valid_in[gi];
      end
    end
  end

  // Lowest set bit of the incoming valid mask and of the pending lanes above ptr.
  always_comb begin
    in_first  = '0;
    skip_next = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (valid_in[i])   in_first  = IW'(i);
      if (above_mask[i]) skip_next = IW'(i);
    end
  end

  assign skip_more  = |above_mask;
  assign last_slot  = (state_reg == SHIFT) &&
                      (SKIP ? !skip_more : (ptr_reg == IW'(LANES - 1)));
  assign ready      = reset_L && ((state_reg == IDLE) || last_slot);
  assign accept     = load && ready;
  // In skip mode an all-invalid group has nothing to emit, so it is not taken.
  assign take       = accept && (!SKIP || (|valid_in));
  assign first_lane = SKIP ? in_first : '0;

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (take) begin
          state_next = SHIFT;
          ptr_next   = first_lane;
        end
      end
      SHIFT: begin
        if (take) begin
          ptr_next = first_lane;
        end else if (last_slot) begin
          state_next = IDLE;
        end else begin
          ptr_next = SKIP ? skip_next : ptr_reg + IW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_f) begin
    if (!reset_L) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      lane_out  <= '0;
      overrun   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      if (load && !ready) overrun <= 1'b1;
      if (state_reg == SHIFT) begin
        data_out  <= hold_valid_reg[ptr_reg] ? hold_data_reg[ptr_reg] : '0;
        valid_out <= hold_valid_reg[ptr_reg];
        lane_out  <= ptr_reg;
      end else begin
        // lane_out keeps the last emitted index while idle.
        data_out  <= '0;
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_muxl1_serializer.sv
// Scoreboard bench: three serializer configurations share a clock and reset;
// stimulus queues expected slots, per-instance monitors pop and compare.
module tb_muxl1_serializer;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  l;
  } exp_t;

  logic clk_f = 1'b0;
  always #5 clk_f = ~clk_f;
  logic reset_L;

  // dut0: 8x4 non-skip, dut1: 8x4 skip, dut2: 16x8 non-skip
  logic [31:0]  d0, d1;
  logic [127:0] d2;
  logic [3:0]   v0, v1;
  logic [7:0]   v2;
  logic         ld0, ld1, ld2;
  logic         rdy0, rdy1, rdy2;
  logic [7:0]   do0, do1;
  logic [15:0]  do2;
  logic         vo0, vo1, vo2;
  logic [1:0]   lo0, lo1;
  logic [2:0]   lo2;
  logic         ov0, ov1, ov2;

  muxl1_serializer #(.WIDTH(8), .LANES(4), .SKIP_INVALID(0)) dut0 (
    .clk_f(clk_f), .reset_L(reset_L), .data_in(d0), .valid_in(v0), .load(ld0),
    .ready(rdy0), .data_out(do0), .valid_out(vo0), .lane_out(lo0), .overrun(ov0));
  muxl1_serializer #(.WIDTH(8), .LANES(4), .SKIP_INVALID(1)) dut1 (
    .clk_f(clk_f), .reset_L(reset_L), .data_in(d1), .valid_in(v1), .load(ld1),
    .ready(rdy1), .data_out(do1), .valid_out(vo1), .lane_out(lo1), .overrun(ov1));
  muxl1_serializer #(.WIDTH(16), .LANES(8), .SKIP_INVALID(0)) dut2 (
    .clk_f(clk_f), .reset_L(reset_L), .data_in(d2), .valid_in(v2), .load(ld2),
    .ready(rdy2), .data_out(do2), .valid_out(vo2), .lane_out(lo2), .overrun(ov2));

  exp_t q0[$], q1[$], q2[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int k, input logic [15:0] d, input logic [3:0] l);
    exp_t e;
    e.d = d;
    e.l = l;
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic tick();
    @(posedge clk_f);
    #1;
  endtask

  // Monitors: every valid slot must match the head of its queue;
  // data_out must be zero whenever valid_out is low.
  always @(negedge clk_f) begin
    exp_t e;
    if (vo0) begin
      if (q0.size() == 0) chk("dut0_unexpected_slot", {24'd0, do0}, 32'hdead);
      else begin
        e = q0.pop_front();
        chk("dut0_data", {24'd0, do0}, {16'd0, e.d});
        chk("dut0_lane", {30'd0, lo0}, {28'd0, e.l});
      end
    end else chk("dut0_idle_zero", {24'd0, do0}, 32'd0);
  end

  always @(negedge clk_f) begin
    exp_t e;
    if (vo1) begin
      if (q1.size() == 0) chk("dut1_unexpected_slot", {24'd0, do1}, 32'hdead);
      else begin
        e = q1.pop_front();
        chk("dut1_data", {24'd0, do1}, {16'd0, e.d});
        chk("dut1_lane", {30'd0, lo1}, {28'd0, e.l});
      end
    end else chk("dut1_idle_zero", {24'd0, do1}, 32'd0);
  end

  always @(negedge clk_f) begin
    exp_t e;
    if (vo2) begin
      if (q2.size() == 0) chk("dut2_unexpected_slot", {16'd0, do2}, 32'hdead);
      else begin
        e = q2.pop_front();
        chk("dut2_data", {16'd0, do2}, {16'd0, e.d});
        chk("dut2_lane", {29'd0, lo2}, {28'd0, e.l});
      end
    end else chk("dut2_idle_zero", {16'd0, do2}, 32'd0);
  end

  initial begin
    // Reset held with load asserted and random data
    reset_L = 1'b0;
    ld0 = 1'b1; ld1 = 1'b1; ld2 = 1'b1;
    d0 = $urandom; d1 = $urandom; d2 = {$urandom, $urandom, $urandom, $urandom};
    v0 = 4'hf; v1 = 4'hf; v2 = 8'hff;
    repeat (3) begin
      tick();
      chk("rst_valid0", {31'd0, vo0}, 32'd0);
      chk("rst_lane0", {30'd0, lo0}, 32'd0);
      chk("rst_ready0", {31'd0, rdy0}, 32'd0);
      chk("rst_ready1", {31'd0, rdy1}, 32'd0);
      chk("rst_ready2", {31'd0, rdy2}, 32'd0);
      chk("rst_overrun0", {31'd0, ov0}, 32'd0);
      chk("rst_overrun2", {31'd0, ov2}, 32'd0);
    end
    ld0 = 1'b0; ld1 = 1'b0; ld2 = 1'b0;
    reset_L = 1'b1;
    #1;
    chk("rel_ready0", {31'd0, rdy0}, 32'd1);
    chk("rel_ready1", {31'd0, rdy1}, 32'd1);
    chk("rel_ready2", {31'd0, rdy2}, 32'd1);
    tick();

    // Single full group on dut0
    d0 = 32'hccddeeff; v0 = 4'hf;
    push(0, 16'hff, 4'd0); push(0, 16'hee, 4'd1); push(0, 16'hdd, 4'd2); push(0, 16'hcc, 4'd3);
    ld0 = 1'b1; tick(); ld0 = 1'b0;
    chk("a_busy", {31'd0, rdy0}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("a_valid", {31'd0, vo0}, 32'd1);
      chk("a_lane_seq", {30'd0, lo0}, i);
    end
    tick();
    chk("a_idle_valid", {31'd0, vo0}, 32'd0);
    chk("a_idle_ready", {31'd0, rdy0}, 32'd1);
    chk("a_idle_lane_hold", {30'd0, lo0}, 32'd3);

    // Back-to-back groups, second loaded in the last slot
    d0 = 32'hccddeeff;
    push(0, 16'hff, 4'd0); push(0, 16'hee, 4'd1); push(0, 16'hdd, 4'd2); push(0, 16'hcc, 4'd3);
    push(0, 16'hbb, 4'd0); push(0, 16'haa, 4'd1); push(0, 16'h99, 4'd2); push(0, 16'h88, 4'd3);
    ld0 = 1'b1; tick(); ld0 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 4) begin
        chk("b_ready_last", {31'd0, rdy0}, 32'd1);
        d0 = 32'h8899aabb;
        ld0 = 1'b1;
      end
      tick();
      ld0 = 1'b0;
      chk("b_gapless", {31'd0, vo0}, 32'd1);
    end
    tick();
    chk("b_end_valid", {31'd0, vo0}, 32'd0);
    chk("b_no_overrun", {31'd0, ov0}, 32'd0);

    // Partial valid, non-skip: invalid slots still occupy cycles
    d0 = 32'h11773322; v0 = 4'b0100;
    push(0, 16'h77, 4'd2);
    ld0 = 1'b1; tick(); ld0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("c_valid_pattern", {31'd0, vo0}, (i == 2) ? 32'd1 : 32'd0);
      chk("c_lane_seq", {30'd0, lo0}, i);
    end
    tick();
    chk("c_end_valid", {31'd0, vo0}, 32'd0);

    // Skip mode: single valid lane
    d1 = 32'h11773322; v1 = 4'b0100;
    push(1, 16'h77, 4'd2);
    ld1 = 1'b1; tick(); ld1 = 1'b0;
    chk("d_ready_single", {31'd0, rdy1}, 32'd1);
    tick();
    chk("d_valid", {31'd0, vo1}, 32'd1);
    chk("d_lane", {30'd0, lo1}, 32'd2);
    tick();
    chk("d_end_valid", {31'd0, vo1}, 32'd0);

    // Skip mode: all-invalid load is a no-op
    v1 = 4'b0000;
    ld1 = 1'b1; tick(); ld1 = 1'b0;
    chk("d_empty_ready", {31'd0, rdy1}, 32'd1);
    repeat (3) begin
      tick();
      chk("d_empty_no_out", {31'd0, vo1}, 32'd0);
    end
    chk("d_empty_no_overrun", {31'd0, ov1}, 32'd0);

    // Skip mode: two sparse lanes
    d1 = 32'ha300a100; v1 = 4'b1010;
    push(1, 16'ha1, 4'd1); push(1, 16'ha3, 4'd3);
    ld1 = 1'b1; tick(); ld1 = 1'b0;
    chk("e_busy", {31'd0, rdy1}, 32'd0);
    tick();
    chk("e_lane_first", {30'd0, lo1}, 32'd1);
    chk("e_ready_last", {31'd0, rdy1}, 32'd1);
    tick();
    chk("e_lane_second", {30'd0, lo1}, 32'd3);
    chk("e_valid_second", {31'd0, vo1}, 32'd1);
    tick();
    chk("e_end_valid", {31'd0, vo1}, 32'd0);

    // Overrun on dut0: second load in slot 1 is dropped
    d0 = 32'hccddeeff; v0 = 4'hf;
    push(0, 16'hff, 4'd0); push(0, 16'hee, 4'd1); push(0, 16'hdd, 4'd2); push(0, 16'hcc, 4'd3);
    ld0 = 1'b1; tick(); ld0 = 1'b0;
    tick();
    chk("f_busy", {31'd0, rdy0}, 32'd0);
    d0 = 32'h44332211;
    ld0 = 1'b1; tick(); ld0 = 1'b0;
    chk("f_overrun_set", {31'd0, ov0}, 32'd1);
    repeat (2) begin
      tick();
      chk("f_group_intact", {31'd0, vo0}, 32'd1);
    end
    repeat (4) begin
      tick();
      chk("f_dropped", {31'd0, vo0}, 32'd0);
      chk("f_overrun_sticky", {31'd0, ov0}, 32'd1);
    end
    // Reset clears overrun and beats a simultaneous load
    reset_L = 1'b0; ld0 = 1'b1;
    tick();
    chk("f_rst_overrun", {31'd0, ov0}, 32'd0);
    chk("f_rst_ready", {31'd0, rdy0}, 32'd0);
    reset_L = 1'b1; ld0 = 1'b0;
    tick();
    chk("f_rel_ready", {31'd0, rdy0}, 32'd1);
    chk("f_rel_no_capture", {31'd0, vo0}, 32'd0);

    // Overrun on the 16x8 instance
    d2 = 128'h8888_7777_6666_5555_4444_3333_2222_1111; v2 = 8'hff;
    for (int i = 0; i < 8; i++) push(2, 16'(16'h1111 * (i + 1)), 4'(i));
    ld2 = 1'b1; tick(); ld2 = 1'b0;
    tick();
    chk("g_busy", {31'd0, rdy2}, 32'd0);
    d2 = {8{16'hbeef}};
    ld2 = 1'b1; tick(); ld2 = 1'b0;
    chk("g_overrun_set", {31'd0, ov2}, 32'd1);
    for (int i = 3; i <= 8; i++) begin
      tick();
      chk("g_group_intact", {31'd0, vo2}, 32'd1);
      if (i == 7) chk("g_ready_last", {31'd0, rdy2}, 32'd1);
    end
    tick();
    chk("g_end_valid", {31'd0, vo2}, 32'd0);
    chk("g_lane_hold", {29'd0, lo2}, 32'd7);
    chk("g_overrun_sticky", {31'd0, ov2}, 32'd1);

    repeat (2) tick();
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    chk("q2_drained", q2.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muxl1_serializer.md
# muxl1_serializer

Parametrised successor to the MUXL1 lane multiplexer: accepts a group of LANES parallel WIDTH-bit lanes, each with its own valid bit, and emits them one lane per clock on a single serial lane with a lane index tag. Lanes are emitted in order, lowest index first. A ready/load handshake, an optional skip-invalid compaction mode, and a sticky overrun flag are added. Upstream sits the lane producers; downstream sits the physical-layer serializer.

## Interface
- WIDTH, 8, bits per lane.
- LANES, 4, number of input lanes; power of two, 2..16.
- SKIP_INVALID, 0, 0 = emit every lane slot; 1 = emit only lanes whose valid bit is set.
- IW, $clog2(LANES), width of lane index (derived, not overridden).

- clk_f  in  1  single clock; all state changes on posedge.
- reset_L  in  1  synchronous, active-low reset.
- data_in  in  WIDTH*LANES  lane i at bits [i*WIDTH +: WIDTH].
- valid_in  in  LANES  bit i qualifies lane i.
- load  in  1  offer a new group; accepted only when ready=1.
- ready  out  1  block can accept a group this cycle.
- data_out  out  WIDTH  serial lane data; 0 whenever valid_out=0.
- valid_out  out  1  data_out qualifier.
- lane_out  out  IW  source lane index of the current output slot.
- overrun  out  1  sticky: a load was offered while ready=0.

## Operation
- Holding registers hold_data[LANES], hold_valid[LANES] are captured from data_in/valid_in on accept (load & ready).
- States: IDLE, SHIFT. Pointer ptr (IW bits).
- IDLE: ready=1. On accept, go to SHIFT with ptr = first lane to emit (lane 0; in skip mode the lowest set bit of valid_in). In skip mode with valid_in=0, accept is a no-op: stay IDLE, nothing emitted, no overrun.
- SHIFT: each cycle register data_out=hold_data[ptr] if hold_valid[ptr] else 0, valid_out=hold_valid[ptr], lane_out=ptr. Then advance ptr to the next lane (non-skip: ptr+1; skip: next set bit above ptr).
- Last slot: ptr=LANES-1 (non-skip), or no set hold_valid bit above ptr (skip). ready=1 during the last slot. Accept there reloads the holding registers and restarts at the new first lane with no bubble. Without an accept, go to IDLE.
- In IDLE, outputs hold valid_out=0, data_out=0, and lane_out at its last value.
- ready is combinational from state/ptr. It is forced to 0 while reset_L=0.
- overrun is set on any cycle where load=1 and ready=0. It is cleared only by reset. The offending group is discarded and the in-flight group is unaffected.

## Timing
- Reset (reset_L=0 at posedge): state=IDLE, ptr=0, holding registers=0, data_out=0, valid_out=0, lane_out=0, overrun=0. Reset mid-group aborts the group; the next cycle after release is IDLE with ready=1.
- Latency: accept at edge k, so the first output slot is registered at edge k+1.
- Non-skip: a group occupies exactly LANES consecutive output cycles. Maximum throughput is one group per LANES cycles, with back-to-back loads giving a gapless stream.
- Skip: a group occupies popcount(valid_in) cycles, minimum 1. A single-valid group has ready=1 in its only slot.
- load with ready=1 and an accept in the same cycle as reset_L=0: reset wins and nothing is captured.

## Test plan
- Reset: hold reset_L=0 for 3 cycles with load=1 and random data -> all outputs 0, ready=0, overrun=0; after release ready=1.
- Non-skip, LANES=4: load once with lanes {ff,ee,dd,cc} and valid 4'hf -> over 4 cycles data_out=ff,ee,dd,cc, lane_out=0,1,2,3, valid_out=1; then IDLE.
- Back-to-back: group {ff,ee,dd,cc}, then load {bb,aa,99,88} in the last slot -> 8 gapless valid slots ff..88, and overrun stays 0.
- Partial valid, non-skip: lanes {x,x,77,x} with valid_in=4'b0100 -> 4 slots with valid_out=0,0,1,0, data_out=0,0,77,0.
- Same stimulus with SKIP_INVALID=1 -> a single slot with data_out=77, lane_out=2, ready=1 in that slot. valid_in=0 with load -> no output.
- Overrun: load again in slot 1 of a non-skip group -> overrun=1 from the next cycle, the current group completes intact, the second group is dropped, and overrun persists until reset. Repeat with WIDTH=16, LANES=8.
